// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and a word-addressed data memory.
// The memory holds a request for as long as the LSU keeps mem_req high and ends it
// with a single mem_ack pulse; mem_rdata is sampled in the same cycle as that ack.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    mem_req;
    logic                    mem_we;
    logic [3:0]              mem_be;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_be,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_be,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-side memory access stage of the single-cycle core.
// The LSU accepts one load or store at a time and stalls the core while the
// access is outstanding. It rejects misaligned accesses without touching memory
// and aborts requests that the memory never acknowledges. Every result is
// reported through a one-cycle done_o pulse.
// Size encoding, shared by loads and stores: 01 word, 10 half, 11 byte, 00 none.
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    input  logic [1:0]            store_size_i,
    input  logic [1:0]            load_size_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misaligned_o,
    output logic                  timeout_o,
    load_store_unit_if.master     mem
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    // A TIMEOUT_CYCLES of 0 disables the abort path. The wrapped limit is then never used.
    localparam logic                 TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    // Byte enables for a store of the given size at the given byte lane.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_WORD: be = 4'b1111;
            SZ_HALF: be = 4'b0011 << lane;
            SZ_BYTE: be = 4'b0001 << lane;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicates the store data across lanes so the enabled lanes always carry the right bytes.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            SZ_WORD: d = wd;
            SZ_HALF: d = {2{wd[15:0]}};
            SZ_BYTE: d = {4{wd[7:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Picks the addressed halfword or byte out of the read word and sign-extends it.
    function automatic logic [31:0] load_data(input logic [1:0] size, input logic [1:0] lane,
                                              input logic [31:0] word);
        logic [31:0] d;
        logic [15:0] half;
        logic [7:0]  byte_v;
        half = lane[1] ? word[31:16] : word[15:0];
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        case (size)
            SZ_WORD: d = word;
            SZ_HALF: d = {{16{half[15]}}, half};
            SZ_BYTE: d = {{24{byte_v[7]}}, byte_v};
            default: d = word;
        endcase
        return d;
    endfunction

    logic [1:0]            state_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [1:0]            size_r;
    logic [1:0]            lane_r;
    logic                  store_r;
    logic                  done_r;
    logic                  misaligned_r;
    logic                  timeout_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic                  mem_req_r;
    logic                  mem_we_r;
    logic [3:0]            mem_be_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r;

    logic                  access_s;
    logic                  is_store_s;
    logic [1:0]            size_s;
    logic                  misaligned_s;
    logic                  stall_s;

    // Decode the incoming instruction. A store takes priority when both sizes are set.
    always_comb begin
        is_store_s   = (store_size_i != 2'b00);
        size_s       = is_store_s ? store_size_i : load_size_i;
        access_s     = req_valid_i & (size_s != 2'b00);
        misaligned_s = 1'b0;
        case (size_s)
            SZ_WORD: misaligned_s = (addr_i[1:0] != 2'b00);
            SZ_HALF: misaligned_s = addr_i[0];
            default: misaligned_s = 1'b0;
        endcase
    end

    // Hold the core while a new access is being accepted or one is outstanding.
    always_comb begin
        stall_s = 1'b0;
        if (state_r == BUSY) begin
            stall_s = 1'b1;
        end else if (state_r == IDLE) begin
            stall_s = access_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Access FSM: accept in IDLE, drive the memory in BUSY, report for one cycle in DONE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_WIDTH{1'b0}};
            size_r       <= 2'b00;
            lane_r       <= 2'b00;
            store_r      <= 1'b0;
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            timeout_r    <= 1'b0;
            rdata_r      <= {DATA_WIDTH{1'b0}};
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_be_r     <= 4'b0000;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r       <= 1'b0;
                    misaligned_r <= 1'b0;
                    timeout_r    <= 1'b0;
                    if (access_s) begin
                        if (misaligned_s) begin
                            state_r      <= DONE;
                            done_r       <= 1'b1;
                            misaligned_r <= 1'b1;
                        end else begin
                            state_r     <= BUSY;
                            cnt_r       <= {CNT_WIDTH{1'b0}};
                            size_r      <= size_s;
                            lane_r      <= addr_i[1:0];
                            store_r     <= is_store_s;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= is_store_s;
                            mem_be_r    <= is_store_s ? store_be(size_s, addr_i[1:0]) : 4'b1111;
                            mem_addr_r  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata_r <= is_store_s ? store_data(size_s, wdata_i)
                                                      : {DATA_WIDTH{1'b0}};
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (mem.mem_ack) begin
                        // An ack at the timeout limit still completes the access normally.
                        state_r   <= DONE;
                        done_r    <= 1'b1;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        mem_be_r  <= 4'b0000;
                        if (!store_r) begin
                            rdata_r <= load_data(size_r, lane_r, mem.mem_rdata);
                        end else begin
                            rdata_r <= rdata_r;
                        end
                    end else if (TIMEOUT_EN && (cnt_r == CNT_LIMIT)) begin
                        state_r   <= DONE;
                        done_r    <= 1'b1;
                        timeout_r <= 1'b1;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        mem_be_r  <= 4'b0000;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    done_r       <= 1'b0;
                    misaligned_r <= 1'b0;
                    timeout_r    <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    done_r       <= 1'b0;
                    misaligned_r <= 1'b0;
                    timeout_r    <= 1'b0;
                    mem_req_r    <= 1'b0;
                    mem_we_r     <= 1'b0;
                    mem_be_r     <= 4'b0000;
                end
            endcase
        end
    end

    assign stall_o       = stall_s;
    assign done_o        = done_r;
    assign misaligned_o  = misaligned_r;
    assign timeout_o     = timeout_r;
    assign rdata_o       = rdata_r;
    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_be    = mem_be_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit. The DUT is built with a short timeout,
// so the abort path and the ack-at-limit corner are both reachable.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic [1:0]  store_size_i;
    logic [1:0]  load_size_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misaligned_o;
    logic        timeout_o;

    int n_checks = 0;
    int n_errors = 0;

    // Per-access observations gathered by run_access.
    int          n_stall;
    int          n_lat;
    int          n_req;
    logic        stable;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [31:0] cap_wdata;

    load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    load_store_unit #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4),
        .CNT_WIDTH     (5)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .store_size_i(store_size_i),
        .load_size_i (load_size_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .misaligned_o(misaligned_o),
        .timeout_o   (timeout_o),
        .mem         (mem_bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one access from IDLE. The memory acks on BUSY cycle number ack_after,
    // counted from 0; a negative value means it never acks. The task returns in the
    // cycle done_o rises, or after a cycle budget runs out.
    task automatic run_access(input logic [1:0] ss, input logic [1:0] ls, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int ack_after);
        int busy_n;
        logic seen;
        busy_n = 0;
        seen   = 1'b0;
        req_valid_i = 1'b1;
        store_size_i = ss;
        load_size_i  = ls;
        addr_i       = a;
        wdata_i      = wd;
        mem_bus.mem_rdata = rd;
        #1;
        n_stall = int'(stall_o);
        n_req   = 0;
        stable  = 1'b1;
        cap_addr = 32'h0; cap_be = 4'h0; cap_we = 1'b0; cap_wdata = 32'h0;
        tick();
        req_valid_i  = 1'b0;
        store_size_i = 2'b00;
        load_size_i  = 2'b00;
        #1;
        n_lat = 1;
        while (!done_o && n_lat < 50) begin
            if (stall_o) n_stall++;
            if (mem_bus.mem_req) begin
                n_req++;
                if (!seen) begin
                    seen = 1'b1;
                    cap_addr = mem_bus.mem_addr; cap_be = mem_bus.mem_be;
                    cap_we = mem_bus.mem_we; cap_wdata = mem_bus.mem_wdata;
                end else if (cap_addr !== mem_bus.mem_addr || cap_be !== mem_bus.mem_be ||
                             cap_we !== mem_bus.mem_we || cap_wdata !== mem_bus.mem_wdata) begin
                    stable = 1'b0;
                end
                if (busy_n == ack_after) mem_bus.mem_ack = 1'b1;
                busy_n++;
            end
            tick();
            mem_bus.mem_ack = 1'b0;
            #1;
            n_lat++;
        end
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        rst_ni = 1'b0;
        req_valid_i = 1'b0; store_size_i = 2'b00; load_size_i = 2'b00;
        addr_i = 32'h0; wdata_i = 32'h0;
        mem_bus.mem_rdata = 32'h0; mem_bus.mem_ack = 1'b0;
        tick(); tick();
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // 1. sw 0x104, ack on the first BUSY cycle
        run_access(2'b01, 2'b00, 32'h104, 32'hDEADBEEF, 32'h0, 0);
        chk("t1_done", 32'(done_o), 32'd1);
        chk("t1_addr", cap_addr, 32'h104);
        chk("t1_be", 32'(cap_be), 32'hF);
        chk("t1_we", 32'(cap_we), 32'd1);
        chk("t1_wdata", cap_wdata, 32'hDEADBEEF);
        chk("t1_lat", 32'(n_lat), 32'd2);
        chk("t1_stall", 32'(n_stall), 32'd2);
        chk("t1_done_stall", 32'(stall_o), 32'd0);
        chk("t1_done_req", 32'({mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be}), 32'd0);
        chk("t1_flags", 32'({misaligned_o, timeout_o}), 32'd0);
        tick();
        chk("t1_pulse", 32'(done_o), 32'd0);

        // 2. lb 0x203, ack on BUSY cycle 3, which is also the timeout limit
        run_access(2'b00, 2'b11, 32'h203, 32'h0, 32'h80FF1234, 3);
        chk("t2_done", 32'(done_o), 32'd1);
        chk("t2_addr", cap_addr, 32'h200);
        chk("t2_be", 32'(cap_be), 32'hF);
        chk("t2_we", 32'(cap_we), 32'd0);
        chk("t2_rdata", rdata_o, 32'hFFFFFF80);
        chk("t2_stall", 32'(n_stall), 32'd5);
        chk("t2_lat", 32'(n_lat), 32'd5);
        chk("t2_no_timeout", 32'(timeout_o), 32'd0);
        chk("t2_stable", 32'(stable), 32'd1);
        tick();

        // 3. sh 0x102, then lh 0x102
        run_access(2'b10, 2'b00, 32'h102, 32'h0000ABCD, 32'h0, 0);
        chk("t3_sh_be", 32'(cap_be), 32'hC);
        chk("t3_sh_wdata", cap_wdata, 32'hABCDABCD);
        chk("t3_sh_addr", cap_addr, 32'h100);
        tick();
        run_access(2'b00, 2'b10, 32'h102, 32'h0, 32'h7FFF0000, 0);
        chk("t3_lh_rdata", rdata_o, 32'h00007FFF);
        chk("t3_lh_we", 32'(cap_we), 32'd0);
        tick();

        // sb to lane 1
        run_access(2'b11, 2'b00, 32'h001, 32'h0000005A, 32'h0, 0);
        chk("sb_be", 32'(cap_be), 32'h2);
        chk("sb_wdata", cap_wdata, 32'h5A5A5A5A);
        tick();

        // 4. misaligned lw
        run_access(2'b00, 2'b01, 32'h101, 32'h0, 32'h12345678, 0);
        chk("t4_done", 32'(done_o), 32'd1);
        chk("t4_mis", 32'(misaligned_o), 32'd1);
        chk("t4_req", 32'(n_req), 32'd0);
        chk("t4_stall", 32'(n_stall), 32'd1);
        chk("t4_rdata_kept", rdata_o, 32'h00007FFF);
        tick();
        chk("t4_mis_clear", 32'({done_o, misaligned_o}), 32'd0);

        // 5. timeout, memory never acks
        run_access(2'b00, 2'b01, 32'h400, 32'h0, 32'hFFFFFFFF, -1);
        chk("t5_done", 32'(done_o), 32'd1);
        chk("t5_timeout", 32'(timeout_o), 32'd1);
        chk("t5_req_cycles", 32'(n_req), 32'd4);
        chk("t5_rdata_kept", rdata_o, 32'h00007FFF);
        chk("t5_req_off", 32'(mem_bus.mem_req), 32'd0);
        tick();
        chk("t5_to_clear", 32'({done_o, timeout_o}), 32'd0);

        // 6. reset during the second BUSY cycle
        req_valid_i = 1'b1; load_size_i = 2'b01; addr_i = 32'h300;
        tick();
        req_valid_i = 1'b0; load_size_i = 2'b00;
        tick();
        chk("t6_busy2_req", 32'(mem_bus.mem_req), 32'd1);
        rst_ni = 1'b0;
        tick();
        chk("t6_rst_req", 32'(mem_bus.mem_req), 32'd0);
        chk("t6_rst_bus", 32'({mem_bus.mem_we, mem_bus.mem_be}), 32'd0);
        chk("t6_rst_rdata", rdata_o, 32'h0);
        chk("t6_rst_flags", 32'({done_o, misaligned_o, timeout_o, stall_o}), 32'd0);
        rst_ni = 1'b1;
        tick();
        run_access(2'b01, 2'b11, 32'h40, 32'h11223344, 32'hCAFEF00D, 0);
        chk("t6_both_done", 32'(done_o), 32'd1);
        chk("t6_both_we", 32'(cap_we), 32'd1);
        chk("t6_both_wdata", cap_wdata, 32'h11223344);
        chk("t6_both_rdata", rdata_o, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
